// File: rtl/systolic_job_arbiter.sv
// Round-robin arbiter sharing one systolic engine between N_REQ requesters, grant locked per job.
// Steers the granted lane's operand/result streams; watchdog aborts a job stalled for TIMEOUT cycles.
module systolic_job_arbiter #(
    parameter int N_REQ     = 2,
    parameter int IN_WORDS  = 8,
    parameter int OUT_WORDS = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_grant,
    input  logic [N_REQ-1:0]      req_in_valid,
    input  logic [N_REQ*64-1:0]   req_in_data,
    output logic [N_REQ-1:0]      req_in_ready,
    output logic [N_REQ-1:0]      req_out_valid,
    output logic [63:0]           req_out_data,
    input  logic [N_REQ-1:0]      req_out_ready,
    output logic [N_REQ-1:0]      job_done,
    output logic [N_REQ-1:0]      job_err,
    output logic                  eng_start,
    output logic                  eng_in_valid,
    output logic [63:0]           eng_in_data,
    input  logic                  eng_in_ready,
    input  logic                  eng_out_valid,
    input  logic [63:0]           eng_out_data,
    output logic                  eng_out_ready,
    input  logic                  eng_done,
    output logic                  eng_abort,
    output logic                  busy
);

    localparam int MAXW = (IN_WORDS > OUT_WORDS) ? IN_WORDS : OUT_WORDS;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int WW   = $clog2(TIMEOUT);
    localparam int GW   = $clog2(N_REQ);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_LOAD, S_DRAIN, S_WAIT_DONE, S_RELEASE, S_ABORT
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [GW-1:0]   r_rr_ptr, r_gnt_idx, w_win;
    logic [CW-1:0]   r_in_cnt, r_out_cnt;
    logic [WW-1:0]   r_wdog;
    logic            r_done_seen;

    logic [N_REQ-1:0] w_gnt_oh;
    logic             w_lane_in_vld, w_lane_out_rdy;
    logic [63:0]      w_lane_in_dat;
    logic             w_in_xfer, w_out_xfer, w_in_work, w_stall, w_wdog_exp;
    logic             w_in_last, w_out_last, w_done_any;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        w_win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[(int'(r_rr_ptr) + i) % N_REQ])
                w_win = GW'((int'(r_rr_ptr) + i) % N_REQ);
        end
    end

    assign w_gnt_oh       = {{(N_REQ-1){1'b0}}, 1'b1} << r_gnt_idx;
    assign w_lane_in_vld  = req_in_valid[r_gnt_idx];
    assign w_lane_in_dat  = req_in_data[{r_gnt_idx, 6'd0} +: 64];
    assign w_lane_out_rdy = req_out_ready[r_gnt_idx];

    assign w_in_xfer  = (r_state == S_LOAD)  && w_lane_in_vld && eng_in_ready;
    assign w_out_xfer = (r_state == S_DRAIN) && eng_out_valid && w_lane_out_rdy;
    assign w_in_work  = (r_state == S_LOAD) || (r_state == S_DRAIN) || (r_state == S_WAIT_DONE);
    assign w_stall    = w_in_work && !w_in_xfer && !w_out_xfer && !eng_done;
    assign w_wdog_exp = w_stall && (r_wdog == WW'(TIMEOUT - 1));
    assign w_in_last  = w_in_xfer  && (r_in_cnt  == CW'(IN_WORDS - 1));
    assign w_out_last = w_out_xfer && (r_out_cnt == CW'(OUT_WORDS - 1));
    assign w_done_any = r_done_seen || eng_done;

    always_comb begin
        w_state_nxt   = r_state;
        req_grant     = (r_state != S_IDLE) ? w_gnt_oh : '0;
        req_in_ready  = '0;
        req_out_valid = '0;
        req_out_data  = '0;
        job_done      = '0;
        job_err       = '0;
        eng_start     = 1'b0;
        eng_in_valid  = 1'b0;
        eng_in_data   = '0;
        eng_out_ready = 1'b0;
        eng_abort     = 1'b0;
        busy          = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: if (|req_valid) w_state_nxt = S_START;
            S_START: begin
                eng_start   = 1'b1;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                eng_in_valid = w_lane_in_vld;
                eng_in_data  = w_lane_in_dat;
                req_in_ready = w_gnt_oh & {N_REQ{eng_in_ready}};
                if (w_wdog_exp)     w_state_nxt = S_ABORT;
                else if (w_in_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                req_out_valid = w_gnt_oh & {N_REQ{eng_out_valid}};
                req_out_data  = eng_out_data;
                eng_out_ready = w_lane_out_rdy;
                if (w_wdog_exp)      w_state_nxt = S_ABORT;
                else if (w_out_last) w_state_nxt = w_done_any ? S_RELEASE : S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (w_done_any)      w_state_nxt = S_RELEASE;
                else if (w_wdog_exp) w_state_nxt = S_ABORT;
            end
            S_RELEASE: begin
                job_done    = w_gnt_oh;
                w_state_nxt = S_IDLE;
            end
            S_ABORT: begin
                job_err     = w_gnt_oh;
                eng_abort   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_gnt_idx   <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_wdog      <= '0;
            r_done_seen <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: if (|req_valid) r_gnt_idx <= w_win;
                S_START: begin
                    r_in_cnt    <= '0;
                    r_out_cnt   <= '0;
                    r_wdog      <= '0;
                    r_done_seen <= 1'b0;
                end
                S_RELEASE, S_ABORT:
                    r_rr_ptr <= (r_gnt_idx == GW'(N_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
                default: ;
            endcase
            if (w_in_xfer)  r_in_cnt    <= r_in_cnt + 1'b1;
            if (w_out_xfer) r_out_cnt   <= r_out_cnt + 1'b1;
            if (w_in_work && eng_done) r_done_seen <= 1'b1;
            // Any handshake or engine completion restarts the stall count.
            if (w_in_work)  r_wdog      <= w_stall ? r_wdog + 1'b1 : '0;
        end
    end

endmodule
